// File: rtl/boid_frame_reader_if.sv
// Bundle between the VGA timing side, display memory,
// buffer writer and the VGA pins for boid_frame_reader.
//
// slave  : the frame reader itself
// master : whoever drives timing, memory data and wr_done
//
// Timing inputs : pix_en, active, x, y, hsync_in,
//                 vsync_in, frame_end
// Writer        : wr_done in, swap_ack / front_sel out
// Memory        : rd_en / rd_addr out, rd_data0/1 in
// Pins          : hsync_out, vsync_out, VGA_R/G/B
// Status        : boid_pixel_count
interface boid_frame_reader_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  pix_en;
  logic                  active;
  logic [9:0]            x;
  logic [8:0]            y;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  frame_end;
  logic                  wr_done;
  logic                  swap_ack;
  logic                  front_sel;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data0;
  logic                  rd_data1;
  logic                  hsync_out;
  logic                  vsync_out;
  logic [3:0]            VGA_R;
  logic [3:0]            VGA_G;
  logic [3:0]            VGA_B;
  logic [15:0]           boid_pixel_count;

  modport slave (
    input  pix_en, active, x, y,
    input  hsync_in, vsync_in, frame_end,
    input  wr_done, rd_data0, rd_data1,
    output swap_ack, front_sel,
    output rd_en, rd_addr,
    output hsync_out, vsync_out,
    output VGA_R, VGA_G, VGA_B,
    output boid_pixel_count
  );

  modport master (
    output pix_en, active, x, y,
    output hsync_in, vsync_in, frame_end,
    output wr_done, rd_data0, rd_data1,
    input  swap_ack, front_sel,
    input  rd_en, rd_addr,
    input  hsync_out, vsync_out,
    input  VGA_R, VGA_G, VGA_B,
    input  boid_pixel_count
  );
endinterface

// File: rtl/boid_frame_reader.sv
// Front-buffer scan-out of the boid display memory:
// 3-stage pixel pipeline plus buffer-swap arbitration.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active high
//   bus   : boid_frame_reader_if.slave
//     stage 0 issues rd_en/rd_addr for (x,y)
//     stage 1 picks the bank bit latched for that pixel
//     stage 2 drives colour and syncs, 2 strobes late
//     swap FSM toggles front_sel at frame_end
//     once the writer reports wr_done
module boid_frame_reader #(
  parameter int          VIDEO_WIDTH  = 640,
  parameter int          VIDEO_HEIGHT = 480,
  parameter int          ADDR_WIDTH   = 19,
  parameter logic [11:0] BOID_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input logic               clock,
  input logic               reset,
  boid_frame_reader_if.slave bus
);

  typedef enum logic [1:0] {
    SHOW,
    ARMED,
    WAIT_LOW
  } swap_st_e;

  // stage 0
  logic [ADDR_WIDTH-1:0] x_ext;
  logic [ADDR_WIDTH-1:0] y_ext;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  in_range;
  logic                  rd_en_d;
  logic                  rd_en_q;
  logic                  act0_q;
  logic                  hs0_q;
  logic                  vs0_q;
  logic                  fe0_q;
  logic                  inr0_q;
  logic                  fsel0_q;

  // stage 1
  logic                  boid_d;
  logic                  boid1_q;
  logic                  act1_q;
  logic                  hs1_q;
  logic                  vs1_q;
  logic                  fe1_q;

  // stage 2
  logic [11:0]           col_d;
  logic [11:0]           col_q;
  logic                  hs2_q;
  logic                  vs2_q;

  // boid counter
  logic                  hit;
  logic [15:0]           cnt_inc;
  logic [15:0]           cnt_d;
  logic [15:0]           cnt_q;
  logic [15:0]           shown_d;
  logic [15:0]           shown_q;

  // swap FSM
  swap_st_e              st_d;
  swap_st_e              st_q;
  logic                  fe_strobe;
  logic                  fsel_d;
  logic                  fsel_q;
  logic                  ack_d;
  logic                  ack_q;

  // x + 640*y without a multiplier
  always_comb begin
    x_ext     = ADDR_WIDTH'(bus.x);
    y_ext     = ADDR_WIDTH'(bus.y);
    rd_addr_d = (y_ext << 9) + (y_ext << 7) + x_ext;
    in_range  = (int'(bus.x) < VIDEO_WIDTH) &&
                (int'(bus.y) < VIDEO_HEIGHT);
    rd_en_d   = bus.active & in_range;
  end

  // bank choice uses the front_sel seen at stage 0,
  // so the pixel in flight at a swap stays on the old buffer
  always_comb begin
    boid_d = 1'b0;
    if (inr0_q) begin
      boid_d = fsel0_q ? bus.rd_data1 : bus.rd_data0;
    end
  end

  always_comb begin
    col_d = 12'h000;
    if (act1_q) begin
      col_d = boid1_q ? BOID_COLOR : BG_COLOR;
    end
  end

  // the frame_end pixel itself is part of the reported total
  always_comb begin
    hit     = act1_q & boid1_q;
    cnt_inc = cnt_q;
    if (hit && (cnt_q != 16'hFFFF)) begin
      cnt_inc = cnt_q + 16'd1;
    end
    cnt_d   = cnt_q;
    shown_d = shown_q;
    if (bus.pix_en) begin
      if (fe1_q) begin
        shown_d = cnt_inc;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      act0_q    <= 1'b0;
      hs0_q     <= 1'b1;
      vs0_q     <= 1'b1;
      fe0_q     <= 1'b0;
      inr0_q    <= 1'b0;
      fsel0_q   <= 1'b0;
      boid1_q   <= 1'b0;
      act1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      fe1_q     <= 1'b0;
      col_q     <= 12'h000;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
    end else if (bus.pix_en) begin
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      act0_q    <= bus.active;
      hs0_q     <= bus.hsync_in;
      vs0_q     <= bus.vsync_in;
      fe0_q     <= bus.frame_end;
      inr0_q    <= in_range;
      fsel0_q   <= fsel_q;
      boid1_q   <= boid_d;
      act1_q    <= act0_q;
      hs1_q     <= hs0_q;
      vs1_q     <= vs0_q;
      fe1_q     <= fe0_q;
      col_q     <= col_d;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shown_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shown_q <= shown_d;
    end
  end

  // wr_done together with frame_end in SHOW swaps at once;
  // WAIT_LOW blocks a second swap on a lingering wr_done
  always_comb begin
    st_d      = st_q;
    fsel_d    = fsel_q;
    ack_d     = 1'b0;
    fe_strobe = bus.pix_en & bus.frame_end;
    unique case (st_q)
      SHOW: begin
        if (bus.wr_done) begin
          if (fe_strobe) begin
            fsel_d = ~fsel_q;
            ack_d  = 1'b1;
            st_d   = WAIT_LOW;
          end else begin
            st_d   = ARMED;
          end
        end
      end
      ARMED: begin
        if (fe_strobe) begin
          fsel_d = ~fsel_q;
          ack_d  = 1'b1;
          st_d   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.wr_done) begin
          st_d = SHOW;
        end
      end
      default: st_d = SHOW;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q   <= SHOW;
      fsel_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      fsel_q <= fsel_d;
      ack_q  <= ack_d;
    end
  end

  assign bus.rd_en            = rd_en_q;
  assign bus.rd_addr          = rd_addr_q;
  assign bus.front_sel        = fsel_q;
  assign bus.swap_ack         = ack_q;
  assign bus.hsync_out        = hs2_q;
  assign bus.vsync_out        = vs2_q;
  assign bus.VGA_R            = col_q[11:8];
  assign bus.VGA_G            = col_q[7:4];
  assign bus.VGA_B            = col_q[3:0];
  assign bus.boid_pixel_count = shown_q;

endmodule
